// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//   Shared constants and types for the 8-way round-robin / fixed-priority
//   arbiter (rr_arbiter) and its winner picker (rr_pick).
//
//   Contents:
//     N               number of requesters (8)
//     IDX_W           width of a requester index (3)
//     CNT_W           width of the grant-cycle counter (8)
//     DEFAULT_TIMEOUT default forced-release limit, in grant cycles
//     arb_state_t     FSM state encoding (IDLE, GRANT)
//     idx_to_onehot   index -> one-hot grant vector helper
// ----------------------------------------------------------------------------
package arb_pkg;

  localparam int N               = 8;
  localparam int IDX_W           = 3;
  localparam int CNT_W           = 8;
  localparam int DEFAULT_TIMEOUT = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Expand a requester index into the one-hot grant vector.
  function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Purely combinational winner selection for the arbiter.
//
//   The search visits indices start, start-1, ..., wrapping from 0 to N-1,
//   and returns the first index whose request bit is set. In fixed-priority
//   mode the start index is forced to N-1, which turns the same descending
//   search into "highest set bit wins".
//
//   Ports:
//     req     [N-1:0]     request vector
//     start   [IDX_W-1:0] first index examined in round-robin mode
//     mode                0 = fixed priority (bit N-1 highest), 1 = round-robin
//     winner  [IDX_W-1:0] selected index (0 when any = 0)
//     any                 at least one request bit is set
// ----------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic             mode,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [IDX_W-1:0] start_eff;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    any       = |req;
    winner    = '0;
    found     = 1'b0;
    idx       = '0;
    start_eff = mode ? start : IDX_W'(N - 1);

    // The subtraction is done at IDX_W bits, so it wraps 0 -> N-1 for free.
    for (int k = 0; k < N; k++) begin
      idx = start_eff - IDX_W'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   8-requester arbiter with selectable fixed-priority or round-robin
//   selection, owner-driven release and a forced release after TIMEOUT grant
//   cycles.
//
//   Handshake: req[i] is a level-held request (valid) that stays high for as
//   long as requester i wants the resource. gnt[i] is the registered
//   acknowledge; once granted, requester i owns the resource until it pulses
//   done, drops req[i], or holds it for TIMEOUT cycles. Every release is
//   followed by at least one IDLE cycle before the next grant.
//
//   Parameters:
//     TIMEOUT      grant cycles before a forced release (legal 1..255)
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous, active-high reset
//     req   [7:0]  request vector, bit i = requester i
//     done         owner finished (looked at only in GRANT)
//     mode         0 = fixed priority, 1 = round-robin (looked at only in IDLE)
//     gnt   [7:0]  registered one-hot grant, zero when nobody owns
//     gnt_id[2:0]  index of the owner, meaningful only while gnt_valid = 1
//     gnt_valid    a grant is held (OR of gnt)
//     timeout_err  one-cycle pulse when a grant is released by the counter alone
//     dbg_state    current FSM state, for observation only
// ----------------------------------------------------------------------------
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  input  logic             mode,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             gnt_valid,
  output logic             timeout_err,
  output arb_state_t       dbg_state
);

  // Limit held one bit wider than the counter so the "count + 1" compare
  // below cannot overflow even when the counter is saturated.
  localparam logic [CNT_W:0] TO_LIM = TIMEOUT[CNT_W:0];

  arb_state_t       state_q;
  logic [IDX_W-1:0] last_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic             normal_rel;
  logic             to_hit;
  logic [CNT_W-1:0] cnt_inc;

  // --------------------------------------------------------------------------
  // Winner selection. The search begins just below the previous owner so the
  // previous owner ends up with the lowest round-robin priority.
  // --------------------------------------------------------------------------
  assign start_idx = last_q - IDX_W'(1);

  rr_pick u_pick (
    .req    (req),
    .start  (start_idx),
    .mode   (mode),
    .winner (pick_idx),
    .any    (pick_any)
  );

  // --------------------------------------------------------------------------
  // Release conditions while in GRANT.
  //   cnt_q counts completed GRANT cycles before the current one, so the
  //   current cycle is grant cycle number cnt_q + 1. Hitting TIMEOUT on that
  //   number gives exactly TIMEOUT cycles of visible grant.
  //   An owner-driven release (done or dropped request) takes precedence, so
  //   a coincident timeout is reported as a normal release.
  // --------------------------------------------------------------------------
  assign normal_rel = done | ~req[gnt_id];
  assign to_hit     = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) >= TO_LIM;
  assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // --------------------------------------------------------------------------
  // FSM with registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt         <= '0;
      gnt_id      <= '0;
      gnt_valid   <= 1'b0;
      timeout_err <= 1'b0;
      cnt_q       <= '0;
      last_q      <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt       <= idx_to_onehot(pick_idx);
            gnt_id    <= pick_idx;
            gnt_valid <= 1'b1;
            last_q    <= pick_idx;
            cnt_q     <= '0;
            state_q   <= GRANT;
          end
        end

        GRANT: begin
          cnt_q <= cnt_inc;
          if (normal_rel || to_hit) begin
            gnt         <= '0;
            gnt_valid   <= 1'b0;
            timeout_err <= ~normal_rel;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q   <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter
//   Self-checking bench for rr_arbiter (TIMEOUT = 4). A behavioural model
//   tracks the owner as an integer, the last winner and the number of grant
//   cycles held; every clock the DUT outputs are compared to it. Directed
//   scenarios are followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_rr_arbiter;

  localparam int TO = 4;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic       mode = 1'b0;

  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout_err;
  arb_pkg::arb_state_t dbg_state;

  always #5 clk = ~clk;

  rr_arbiter #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .mode        (mode),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .gnt_valid   (gnt_valid),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // Scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner = -1 when nobody holds the resource.
  int m_owner = -1;
  int m_last  = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d, input logic m, input logic rs);
    int w;
    m_to = 1'b0;
    if (rs) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (r != 8'h00) begin
        w = -1;
        if (!m) begin
          for (int i = 7; i >= 0; i--) begin
            if (w < 0 && r[i]) w = i;
          end
        end else begin
          for (int k = 1; k <= 8; k++) begin
            int j;
            j = (m_last - k + 16) % 8;
            if (w < 0 && r[j]) w = j;
          end
        end
        m_owner = w;
        m_last  = w;
        m_held  = 0;
      end
    end else begin
      m_held++;
      if (d || !r[m_owner]) begin
        m_owner = -1;
      end else if (m_held >= TO) begin
        m_owner = -1;
        m_to    = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    check_eq({tag, ".gnt"},       32'(gnt),         32'(eg));
    check_eq({tag, ".gnt_valid"}, 32'(gnt_valid),   32'(m_owner >= 0));
    check_eq({tag, ".timeout"},   32'(timeout_err), 32'(m_to));
    check_eq({tag, ".state"},     32'(dbg_state),   32'(m_owner >= 0));
    if (m_owner >= 0) check_eq({tag, ".gnt_id"}, 32'(gnt_id), 32'(m_owner));
  endtask

  // Driver: one clock cycle with the given inputs, then compare with the model.
  task automatic step(input string tag, input logic [7:0] r, input logic d,
                      input logic m, input logic rs);
    @(negedge clk);
    req  = r;
    done = d;
    mode = m;
    rst  = rs;
    @(posedge clk);
    model_edge(r, d, m, rs);
    #1;
    compare_all(tag);
  endtask

  initial begin
    // Reset state
    model_reset();
    #2;
    check_eq("rst.gnt",    32'(gnt),         32'h0);
    check_eq("rst.gnt_id", 32'(gnt_id),      32'h0);
    check_eq("rst.valid",  32'(gnt_valid),   32'h0);
    check_eq("rst.to",     32'(timeout_err), 32'h0);
    step("rst_hold", 8'h2C, 1'b0, 1'b0, 1'b1);

    // Fixed priority, req = 0010_1100 held
    step("fix_g1", 8'h2C, 1'b0, 1'b0, 1'b0);
    check_eq("fix_g1.exp", 32'(gnt), 32'h20);
    check_eq("fix_g1.id",  32'(gnt_id), 32'd5);
    step("fix_rel", 8'h2C, 1'b1, 1'b0, 1'b0);
    check_eq("fix_rel.exp", 32'(gnt), 32'h00);
    step("fix_g2", 8'h2C, 1'b0, 1'b0, 1'b0);
    check_eq("fix_g2.exp", 32'(gnt), 32'h20);
    step("fix_rel2", 8'h00, 1'b1, 1'b0, 1'b0);
    step("idle0", 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("idle0.exp", 32'(gnt_valid), 32'h0);

    // Round-robin full rotation from reset
    step("rr_rst", 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i <= 8; i++) begin
      step("rr_g", 8'hFF, 1'b0, 1'b1, 1'b0);
      check_eq("rr_order", 32'(gnt_id), 32'((15 - i) % 8));
      step("rr_rel", 8'hFF, 1'b1, 1'b1, 1'b0);
      check_eq("rr_idle", 32'(gnt_valid), 32'h0);
    end
    step("rr_end", 8'h00, 1'b0, 1'b1, 1'b0);

    // Timeout: exactly TO cycles of grant, one-cycle pulse, re-grant
    for (int i = 0; i < TO; i++) begin
      step("to_hold", 8'h01, 1'b0, 1'b0, 1'b0);
      check_eq("to_hold.exp", 32'(gnt), 32'h01);
    end
    step("to_rel", 8'h01, 1'b0, 1'b0, 1'b0);
    check_eq("to_rel.gnt", 32'(gnt), 32'h00);
    check_eq("to_rel.err", 32'(timeout_err), 32'h1);
    step("to_regrant", 8'h01, 1'b0, 1'b0, 1'b0);
    check_eq("to_regrant.gnt", 32'(gnt), 32'h01);
    check_eq("to_regrant.err", 32'(timeout_err), 32'h0);

    // done coincident with timeout: normal release
    for (int i = 1; i < TO; i++) step("tod_hold", 8'h01, 1'b0, 1'b0, 1'b0);
    step("tod_rel", 8'h01, 1'b1, 1'b0, 1'b0);
    check_eq("tod_rel.err", 32'(timeout_err), 32'h0);
    check_eq("tod_rel.gnt", 32'(gnt), 32'h00);
    step("tod_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Owner drops its request
    step("drop_g", 8'h0C, 1'b0, 1'b0, 1'b0);
    check_eq("drop_g.id", 32'(gnt_id), 32'd3);
    step("drop_rel", 8'h04, 1'b0, 1'b0, 1'b0);
    check_eq("drop_rel.gnt", 32'(gnt), 32'h00);
    check_eq("drop_rel.err", 32'(timeout_err), 32'h0);
    step("drop_next", 8'h04, 1'b0, 1'b0, 1'b0);
    check_eq("drop_next.gnt", 32'(gnt), 32'h04);
    step("drop_end", 8'h00, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant to bit 7
    step("arst_g", 8'h80, 1'b0, 1'b0, 1'b0);
    check_eq("arst_g.gnt", 32'(gnt), 32'h80);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("arst.gnt",   32'(gnt),         32'h0);
    check_eq("arst.valid", 32'(gnt_valid),   32'h0);
    check_eq("arst.err",   32'(timeout_err), 32'h0);
    step("arst_hold", 8'h81, 1'b0, 1'b1, 1'b1);
    step("arst_first", 8'h81, 1'b0, 1'b1, 1'b0);
    check_eq("arst_first.gnt", 32'(gnt), 32'h80);

    // Randomized run
    begin
      logic [7:0] r;
      logic       d;
      logic       m;
      logic       rs;
      r = 8'h81;
      m = 1'b1;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0) r = 8'($urandom) & 8'($urandom);
          else r = 8'($urandom);
        end
        if ($urandom_range(0, 15) == 0) m = ~m;
        d  = ($urandom_range(0, 5) == 0);
        rs = ($urandom_range(0, 99) == 0);
        step("rand", r, d, m, rs);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum grant cycles before a forced release (legal range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req  input  8  request vector, bit i = requester i; level-held while the requester wants the resource.
REQ-005 Port: done  input  1  current owner finished; sampled only in GRANT.
REQ-006 Port: mode  input  1  0 = fixed priority (bit 7 highest), 1 = round-robin; sampled only in IDLE.
REQ-007 Port: gnt  output  8  one-hot grant, registered; all-zero when no owner.
REQ-008 Port: gnt_id  output  3  binary index of the owner; valid only while gnt_valid = 1.
REQ-009 Port: gnt_valid  output  1  high while any grant is held; equals OR of gnt.
REQ-010 Port: timeout_err  output  1  one-cycle pulse on a forced release.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 IDLE with req = 0: stay in IDLE with gnt = 0.
REQ-013 IDLE with req != 0: select a winner, load gnt, gnt_id and gnt_valid on the same edge, then go to GRANT.
- Latency from req asserted to gnt visible is 1 cycle.
REQ-014 Fixed mode: the winner is the highest set index of req.
REQ-015 Round-robin mode: the search starts at index (last - 1) mod 8 and descends with wrap from 0 to 7.
- last is the index of the most recent grant.
- The last owner therefore has the lowest priority.
REQ-016 last SHALL update to the winner's index on every grant, in both modes.
REQ-017 GRANT: hold gnt and gnt_id unchanged until a release condition occurs.
- Other req changes have no effect while in GRANT.
REQ-018 Release conditions: done = 1, or req[gnt_id] = 0, or the grant cycle counter reaches TIMEOUT.
- On release: clear gnt and gnt_valid at the next edge and return to IDLE.
REQ-019 Every release SHALL be followed by at least one IDLE cycle, so back-to-back grants are at least 2 cycles apart.
REQ-020 Grant cycle counter:
- 8 bits wide.
- Cleared on entry to GRANT.
- Increments each GRANT cycle.
- Saturates; it never wraps.
REQ-021 timeout_err SHALL pulse for exactly one cycle only when release is caused solely by the counter.
REQ-022 done or a dropped request in the same cycle as a timeout SHALL count as a normal release, with timeout_err = 0.
REQ-023 A mode change during GRANT SHALL take effect at the next IDLE arbitration.

Reset
REQ-024 On rst asserted, these SHALL take effect immediately, regardless of clk:
- State = IDLE.
- gnt = 0, gnt_id = 0, gnt_valid = 0, timeout_err = 0.
- Counter = 0.
- last = 0, so the first round-robin search starts at index 7.
REQ-025 Reset asserted mid-grant SHALL drop the grant with no timeout_err pulse.
- The first arbitration after deassertion occurs on the first rising edge with rst = 0.

Structure
REQ-026 Shared package arb_pkg SHALL hold:
- Requester count N = 8.
- Index width 3.
- The state enumeration (IDLE, GRANT).
- The default TIMEOUT constant.
REQ-027 One combinational sub-module, rr_pick, SHALL compute the winner.
- Inputs: req, start index, mode.
- Outputs: winner index and any-request flag.
- It is instantiated once.

Verification
REQ-028 Fixed mode, reset, req = 8'b00101100 held:
- gnt = 8'b00100000 and gnt_id = 5 one cycle later.
- done pulse -> gnt = 0 next cycle.
- Next grant to bit 5 again.
REQ-029 Round-robin mode, req = 8'hFF held, done pulsed in each GRANT cycle:
- Grant order is 7, 6, 5, ..., 0, 7.
- Each grant is separated by exactly one IDLE cycle.
REQ-030 TIMEOUT = 4, req = 8'b00000001 held, done = 0:
- gnt held for 4 cycles, then released.
- timeout_err = 1 for exactly one cycle.
- Re-grant after one IDLE cycle.
REQ-031 done = 1 in the same cycle the counter reaches TIMEOUT:
- Release occurs with timeout_err = 0.
REQ-032 rst asserted asynchronously between clock edges while gnt = 8'b10000000:
- gnt = 0 and gnt_valid = 0 immediately.
- After deassertion with req = 8'h81 in round-robin mode, the first grant is to bit 7.
REQ-033 Owner drops req[gnt_id] with done = 0:
- Release at the next edge with no timeout_err.
- The next winner is chosen per mode.
